fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the core's decode logic.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready interface.
- Supports a redirect input (branch/jump target) that flushes in-flight and buffered instructions.

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: owns the PC, issues single-outstanding word fetches and buffers {instr, pc} for decode.
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetch_count/flush_count outputs. Rev 1.0
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
`endif
);

   localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REQ         = 2'd1,
      REQ_DISCARD = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          push;
   logic          pop;
   logic [31:0]   target_pc;
   logic [31:0]   pc_plus4;
   logic          unused_pc_bits;

   assign target_pc      = {redirect_pc[31:2], 2'b00};
   assign unused_pc_bits = ^redirect_pc[1:0];
   assign pc_plus4       = fetch_pc + 32'd4;

   // A redirect suppresses both the push of the returning word and the pop by decode.
   assign push       = (state == REQ) && imem_ack && !redirect_valid;
   assign pop        = (count != '0) && instr_ready && !redirect_valid;
   assign count_next = count + CW'(push) - CW'(pop);

   assign instr_valid = (count != '0);
   assign instr       = fifo_data[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   // In REQ, fetch_pc always equals imem_addr; it only diverges once a redirect moves us to REQ_DISCARD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_valid) begin
                  fetch_pc <= target_pc;
               end else if (count < DEPTH_C) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            REQ: begin
               if (redirect_valid) begin
                  fetch_pc <= target_pc;
                  if (imem_ack) begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end else begin
                     state <= REQ_DISCARD;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= pc_plus4;
                  if (count_next < DEPTH_C) begin
                     imem_addr <= pc_plus4;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            REQ_DISCARD: begin
               if (redirect_valid) begin
                  fetch_pc <= target_pc;
               end
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   // Flush keeps rd_ptr so the (invalid) head output stays stable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]   <= imem_addr;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (push) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (redirect_valid) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed stimulus, queue-level reference model checked every cycle, plus literal checkpoints.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0100;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] DKEY       = 32'hC0DE_5A5A;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetch_count;
   logic [31:0] flush_count;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .fetch_count   (fetch_count),
      .flush_count   (flush_count)
`endif
   );

   // Memory returns a word derived from its address so every slot is distinguishable.
   assign imem_data = imem_addr ^ DKEY;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding flag, discard flag, PC, issued address and a queue of {word, pc}.
   bit          m_out;
   bit          m_disc;
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   logic [63:0] q[$];
   logic [31:0] m_fetch;
   logic [31:0] m_flush;
   int          m_size0;
   bit          m_push;
   bit          m_pop;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_out = 0; m_disc = 0; m_pc = RESET_PC; m_addr = RESET_PC;
         q.delete(); m_fetch = 0; m_flush = 0;
      end else begin
         m_size0 = q.size();
         m_push  = m_out && !m_disc && imem_ack && !redirect_valid;
         m_pop   = (m_size0 != 0) && instr_ready && !redirect_valid;
         if (redirect_valid) begin
            q.delete();
            m_flush = m_flush + 1;
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
               q.push_back({m_addr ^ DKEY, m_addr});
               m_fetch = m_fetch + 1;
            end
         end
         if (!m_out) begin
            if (redirect_valid) m_pc = redirect_pc & ~32'd3;
            else if (m_size0 < FIFO_DEPTH) begin
               m_out = 1; m_disc = 0; m_addr = m_pc;
            end
         end else if (redirect_valid) begin
            m_pc = redirect_pc & ~32'd3;
            if (imem_ack) m_out = 0;
            else m_disc = 1;
         end else if (imem_ack) begin
            if (m_disc) m_out = 0;
            else begin
               m_pc = m_pc + 32'd4;
               if (q.size() < FIFO_DEPTH) m_addr = m_pc;
               else m_out = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset) begin
         check("m_req", {31'd0, imem_req}, {31'd0, m_out});
         if (m_out) check("m_addr", imem_addr, m_addr);
         check("m_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0) begin
            check("m_instr", instr, q[0][63:32]);
            check("m_instr_pc", instr_pc, q[0][31:0]);
         end
`ifdef FETCH_PERF_COUNTERS_EN
         check("m_fetch_count", fetch_count, m_fetch);
         check("m_flush_count", flush_count, m_flush);
`endif
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [31:0] popped[$];
   bit          seen;
   logic [39:0] ack_pat;
   logic [39:0] rdy_pat;
   logic [39:0] rv_pat;

   initial begin
      reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h100);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);

      // Zero-wait streaming
      reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      check("t1_addr0", imem_addr, 32'h100);
      check("t1_req0", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      check("t1_addr1", imem_addr, 32'h104);
      check("t1_pc1", instr_pc, 32'h100);
      @(negedge clk);
      check("t1_addr2", imem_addr, 32'h108);
      check("t1_pc2", instr_pc, 32'h104);
      check("t1_valid", {31'd0, instr_valid}, 32'd1);

      // Fill with decode stalled, then drain
      do_reset();
      instr_ready = 1'b0; imem_ack = 1'b1;
      repeat (5) @(negedge clk);
      check("t2_full_req", {31'd0, imem_req}, 32'd0);
      repeat (3) @(negedge clk);
      check("t2_hold_req", {31'd0, imem_req}, 32'd0);
      check("t2_head", instr_pc, 32'h100);
      instr_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (instr_valid) popped.push_back(instr_pc);
         if (imem_req && !seen) begin
            seen = 1;
            check("t2_resume_addr", imem_addr, 32'h110);
         end
         @(negedge clk);
      end
      check("t2_resumed", {31'd0, seen}, 32'd1);
      for (int i = 0; i < 6; i++) check("t2_order", popped[i], 32'h100 + 32'(4 * i));

      // Redirect during a slow request
      do_reset();
      imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      check("t3_addr_w0", imem_addr, 32'h100);
      redirect_valid = 1'b1; redirect_pc = 32'h2002;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t3_addr_w1", imem_addr, 32'h100);
      @(negedge clk);
      check("t3_addr_w2", imem_addr, 32'h100);
      check("t3_req_w2", {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b1;
      @(negedge clk);
      check("t3_dropped", {31'd0, instr_valid}, 32'd0);
      check("t3_idle", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      check("t3_new_addr", imem_addr, 32'h2000);
      @(negedge clk);
      check("t3_first_pc", instr_pc, 32'h2000);
      check("t3_first_valid", {31'd0, instr_valid}, 32'd1);

      // Redirect coincident with ack, push and pop
      redirect_valid = 1'b1; redirect_pc = 32'h3000;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t4_flushed", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      check("t4_addr", imem_addr, 32'h3000);
      @(negedge clk);
      check("t4_pc", instr_pc, 32'h3000);

      // Address wrap, with low target bits masked
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check("t5_addr_wrap", imem_addr, 32'h0000_0000);
      check("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      check("t5_pc_wrap", instr_pc, 32'h0000_0000);

      // Asynchronous reset with a request outstanding
      imem_ack = 1'b0;
      @(negedge clk);
      check("t6_req_before", {31'd0, imem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_req_async", {31'd0, imem_req}, 32'd0);
      check("t6_valid_async", {31'd0, instr_valid}, 32'd0);
      imem_ack = 1'b1;
      @(negedge clk);
      check("t6_rst_addr", imem_addr, 32'h100);
      check("t6_rst_instr", instr, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
      check("t6_fetch_count", fetch_count, 32'd0);
      check("t6_flush_count", flush_count, 32'd0);
`endif
      reset = 1'b1;
      @(negedge clk);
      check("t6_restart_addr", imem_addr, 32'h100);
      check("t6_restart_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      check("t6_restart_pc", instr_pc, 32'h100);

      // Mixed ack/ready/redirect pattern, checked by the model
      ack_pat = 40'hB6_D5A3_9E71;
      rdy_pat = 40'h3C_0F19_E6A5;
      rv_pat  = 40'h01_0020_0400;
      for (int i = 0; i < 40; i++) begin
         imem_ack       = ack_pat[i];
         instr_ready    = rdy_pat[i];
         redirect_valid = rv_pat[i];
         redirect_pc    = 32'h4000 + 32'(i) * 32'd16 + 32'd1;
         @(negedge clk);
      end
      redirect_valid = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
